// File: rtl/mem_bus_pkg.sv
// Shared native-memory-bus definitions: data/address width, fetch FSM states and
// the word-alignment mask.
package mem_bus_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [XLEN-1:0] ALIGN_MASK = 32'hFFFF_FFFC;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StDiscard
  } fetch_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Synchronous FIFO with synchronous flush; flush overrides push and pop in the same cycle.
// Pushes to a full FIFO and pops from an empty one are ignored.
module sync_fifo #(
  parameter int unsigned WIDTH = 64,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       resetn,
  input  logic                       i_flush,
  input  logic                       i_push,
  input  logic [WIDTH-1:0]           i_data,
  input  logic                       i_pop,
  output logic                       o_valid,
  output logic [WIDTH-1:0]           o_data,
  output logic [$clog2(DEPTH):0]     o_count
);

  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = AW + 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW-1:0]    r_wptr;
  logic [AW-1:0]    r_rptr;
  logic [CW-1:0]    r_count;

  logic w_push;
  logic w_pop;

  assign w_push = resetn && !i_flush && i_push && (r_count != CW'(DEPTH));
  assign w_pop  = resetn && !i_flush && i_pop && (r_count != '0);

  always_ff @(posedge clk) begin
    if (!resetn || i_flush) begin
      r_wptr  <= '0;
      r_rptr  <= '0;
      r_count <= '0;
    end else begin
      if (w_push) r_wptr <= r_wptr + AW'(1);
      if (w_pop)  r_rptr <= r_rptr + AW'(1);
      if (w_push && !w_pop)      r_count <= r_count + CW'(1);
      else if (w_pop && !w_push) r_count <= r_count - CW'(1);
    end
  end

  // Storage needs no reset; validity is tracked by r_count.
  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_data;
  end

  assign o_valid = (r_count != '0);
  assign o_data  = r_mem[r_rptr];
  assign o_count = r_count;

endmodule

// File: rtl/mem_fetch_prefetcher.sv
// Sequential word prefetcher on the native memory bus: one outstanding read at a time,
// results buffered in a FIFO; a redirect flushes the buffer and restarts at a new address.
module mem_fetch_prefetcher
  import mem_bus_pkg::*;
#(
  parameter int unsigned     DEPTH      = 4,
  parameter logic [XLEN-1:0] RESET_ADDR = 32'h0000_0000
) (
  input  logic            clk,
  input  logic            resetn,
  output logic            mem_valid,
  input  logic            mem_ready,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic [3:0]      mem_wstrb,
  input  logic [XLEN-1:0] mem_rdata,
  input  logic            redirect_valid,
  input  logic [XLEN-1:0] redirect_addr,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_data,
  output logic [XLEN-1:0] out_addr
);

  localparam int unsigned CW = $clog2(DEPTH) + 1;

  fetch_state_e    r_state;
  logic            r_mem_valid;
  logic [XLEN-1:0] r_mem_addr;
  logic [XLEN-1:0] r_fetch_pc;

  logic              w_push;
  logic              w_pop;
  logic [2*XLEN-1:0] w_head;
  logic [CW-1:0]     w_count;

  // A redirect in the response cycle drops the word instead of buffering it.
  assign w_push = (r_state == StReq) && mem_ready && !redirect_valid;
  assign w_pop  = out_valid && out_ready;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      r_state     <= StIdle;
      r_mem_valid <= 1'b0;
      r_mem_addr  <= '0;
      r_fetch_pc  <= RESET_ADDR & ALIGN_MASK;
    end else begin
      unique case (r_state)
        StIdle: begin
          if (redirect_valid) begin
            r_fetch_pc <= redirect_addr & ALIGN_MASK;
          end else if (w_count < CW'(DEPTH)) begin
            r_mem_valid <= 1'b1;
            r_mem_addr  <= r_fetch_pc;
            r_state     <= StReq;
          end
        end
        StReq: begin
          if (redirect_valid) begin
            r_fetch_pc <= redirect_addr & ALIGN_MASK;
            if (mem_ready) begin
              r_mem_valid <= 1'b0;
              r_state     <= StIdle;
            end else begin
              r_state <= StDiscard;
            end
          end else if (mem_ready) begin
            r_fetch_pc  <= r_fetch_pc + 32'd4;
            r_mem_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        StDiscard: begin
          if (redirect_valid) r_fetch_pc <= redirect_addr & ALIGN_MASK;
          if (mem_ready) begin
            r_mem_valid <= 1'b0;
            r_state     <= StIdle;
          end
        end
        default: begin
          r_mem_valid <= 1'b0;
          r_state     <= StIdle;
        end
      endcase
    end
  end

  sync_fifo #(
    .WIDTH(2 * XLEN),
    .DEPTH(DEPTH)
  ) u_fifo (
    .clk    (clk),
    .resetn (resetn),
    .i_flush(redirect_valid),
    .i_push (w_push),
    .i_data ({mem_rdata, r_mem_addr}),
    .i_pop  (w_pop),
    .o_valid(out_valid),
    .o_data (w_head),
    .o_count(w_count)
  );

  assign mem_valid = r_mem_valid;
  assign mem_addr  = r_mem_addr;
  assign mem_wdata = '0;
  assign mem_wstrb = '0;
  assign out_data  = w_head[2*XLEN-1:XLEN];
  assign out_addr  = w_head[XLEN-1:0];

endmodule

// File: tb/tb_mem_fetch_prefetcher.sv
// Randomised scoreboard bench for mem_fetch_prefetcher with a transaction-level model
// of the fetch stream and a bench-side single-cycle memory responder.
module tb_mem_fetch_prefetcher;

  localparam int unsigned DEPTH      = 4;
  localparam logic [31:0] RESET_ADDR = 32'h0000_0100;

  logic        clk = 1'b0;
  logic        resetn;
  logic        mem_valid;
  logic        mem_ready;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic [31:0] mem_rdata;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic [31:0] out_addr;

  int vectors = 0;
  int miscompares = 0;

  // Responder controls.
  bit hold_ready = 1'b0;
  bit fast_ready = 1'b1;

  mem_fetch_prefetcher #(
    .DEPTH     (DEPTH),
    .RESET_ADDR(RESET_ADDR)
  ) dut (
    .clk           (clk),
    .resetn        (resetn),
    .mem_valid     (mem_valid),
    .mem_ready     (mem_ready),
    .mem_addr      (mem_addr),
    .mem_wdata     (mem_wdata),
    .mem_wstrb     (mem_wstrb),
    .mem_rdata     (mem_rdata),
    .redirect_valid(redirect_valid),
    .redirect_addr (redirect_addr),
    .out_valid     (out_valid),
    .out_ready     (out_ready),
    .out_data      (out_data),
    .out_addr      (out_addr)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] mem_func(input logic [31:0] a);
    return (a * 32'h9E37_79B9) ^ 32'h1234_5678;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- reference model + monitor ----------------
  logic [63:0] exp_q[$];
  logic [31:0] model_pc;
  logic [31:0] req_addr;
  bit          outstanding;
  bit          discard;
  bit          exp_valid;
  bit          just_reset;
  bit          started = 1'b0;

  always @(negedge clk) begin
    if (resetn === 1'b0) begin
      exp_q.delete();
      outstanding = 1'b0;
      discard     = 1'b0;
      exp_valid   = 1'b0;
      model_pc    = RESET_ADDR & 32'hFFFF_FFFC;
      just_reset  = 1'b1;
      started     = 1'b1;
    end else if (started) begin
      int unsigned cnt;
      logic [63:0] head;
      cnt = exp_q.size();
      check("mem_valid", {31'd0, mem_valid}, {31'd0, exp_valid});
      check("mem_wstrb", {28'd0, mem_wstrb}, 32'd0);
      check("mem_wdata", mem_wdata, 32'd0);
      if (exp_valid) check("mem_addr", mem_addr, req_addr);
      if (just_reset) check("mem_addr_after_reset", mem_addr, 32'd0);
      just_reset = 1'b0;
      check("out_valid", {31'd0, out_valid}, {31'd0, (cnt != 0)});
      if (out_valid && out_ready && !redirect_valid && cnt != 0) begin
        head = exp_q.pop_front();
        check("out_data", out_data, head[63:32]);
        check("out_addr", out_addr, head[31:0]);
      end
      // Fetch stream update for the coming edge.
      if (redirect_valid) begin
        exp_q.delete();
        model_pc = redirect_addr & 32'hFFFF_FFFC;
        if (outstanding) begin
          if (mem_ready) begin
            outstanding = 1'b0;
            discard     = 1'b0;
          end else begin
            discard = 1'b1;
          end
        end
      end else if (outstanding) begin
        if (mem_ready) begin
          if (!discard) begin
            exp_q.push_back({mem_func(req_addr), req_addr});
            model_pc = model_pc + 32'd4;
          end
          outstanding = 1'b0;
          discard     = 1'b0;
        end
      end else if (cnt < DEPTH) begin
        outstanding = 1'b1;
        req_addr    = model_pc;
      end
      exp_valid = outstanding;
    end
  end

  // ---------------- stimulus ----------------
  task automatic step();
    @(posedge clk);
    #1;
    resetn         = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = $urandom();
    mem_ready      = mem_valid && !hold_ready && (fast_ready || ($urandom_range(0, 2) == 0));
    mem_rdata      = mem_ready ? mem_func(mem_addr) : $urandom();
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic wait_mem_valid(input string name);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      if (mem_valid === 1'b1) begin
        seen = 1'b1;
        break;
      end
      step();
    end
    vectors++;
    if (!seen) begin
      miscompares++;
      $display("FAIL %s: mem_valid timeout, got 0, expected 1", name);
    end
  endtask

  task automatic redirect_now(input logic [31:0] a);
    redirect_valid = 1'b1;
    redirect_addr  = a;
  endtask

  initial begin
    resetn         = 1'b0;
    mem_ready      = 1'b0;
    mem_rdata      = '0;
    redirect_valid = 1'b0;
    redirect_addr  = '0;
    out_ready      = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    resetn = 1'b0;

    // Sequential fetch from RESET_ADDR with an always-ready consumer.
    run(15);

    // Consumer stalls: FIFO fills to DEPTH then fetching stops; resumes after release.
    out_ready = 1'b0;
    run(25);
    out_ready = 1'b1;
    run(15);

    // Redirect while a request is waiting for its response.
    hold_ready = 1'b1;
    wait_mem_valid("redirect_req_wait");
    redirect_now(32'h0000_2002);
    run(3);
    hold_ready = 1'b0;
    run(12);

    // Redirect coincident with the response strobe.
    hold_ready = 1'b1;
    wait_mem_valid("redirect_ready_wait");
    step();
    mem_ready = 1'b1;
    mem_rdata = mem_func(mem_addr);
    redirect_now(32'h0000_3000);
    hold_ready = 1'b0;
    run(10);

    // Address wrap at the top of the space.
    step();
    redirect_now(32'hFFFF_FFF8);
    run(15);

    // Reset in the middle of an outstanding request.
    hold_ready = 1'b1;
    wait_mem_valid("reset_wait");
    resetn = 1'b0;
    step();
    hold_ready = 1'b0;
    run(12);

    // Randomised traffic.
    fast_ready = 1'b0;
    for (int i = 0; i < 3000; i++) begin
      step();
      out_ready = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 39) == 0) begin
        redirect_now(($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15))
                                                 : $urandom());
      end
      if ($urandom_range(0, 599) == 0) resetn = 1'b0;
    end
    run(5);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
